rv32imf_apu_dispatcher: RTL

Core-side APU master. It takes decoded FP operations from the ID/EX stage and drives the APU request channel (req/gnt, operands, op, flags) into the FP wrapper. It tracks in-flight destination registers in an in-order scoreboard FIFO and turns APU responses (rvalid/rdata/rflags) into register-file writebacks. It also accumulates the sticky fflags.

---
 rtl/rv32imf_apu_core_pkg.sv | 21 ++
 rtl/rv32imf_apu_rd_fifo.sv | 70 +++++++
 rtl/rv32imf_apu_dispatcher.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rv32imf_apu_core_pkg.sv
// Shared APU widths, the latched request bundle and the request FSM encoding
// used by the dispatcher and its rd scoreboard.
package rv32imf_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 11;
  localparam int APU_NUSFLAGS_CPU = 5;

  typedef struct packed {
    logic [APU_NARGS_CPU*32-1:0]  operands;
    logic [APU_WOP_CPU-1:0]       op;
    logic [APU_NDSFLAGS_CPU-1:0]  flags;
  } apu_req_t;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_PEND = 1'b1
  } req_state_e;

endpackage

// File: rtl/rv32imf_apu_rd_fifo.sv
// In-order scoreboard of destination registers for in-flight APU ops, with a
// parallel RAW compare of the issuing op's source registers against live entries.
module rv32imf_apu_rd_fifo #(
  parameter int  DEPTH  = 4,
  parameter int  REG_AW = 6,
  parameter int  NARGS  = 3,
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [REG_AW-1:0]       push_rd_i,
  input  logic                    pop_i,
  input  logic                    excl_head_i,
  input  logic [NARGS*REG_AW-1:0] cmp_addr_i,
  input  logic [NARGS-1:0]        cmp_en_i,
  output logic [NARGS-1:0]        hit_o,
  output logic [REG_AW-1:0]       head_rd_o,
  output logic [PW:0]             count_o
);

  logic [REG_AW-1:0] rd_mem [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW:0]       count_q;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int e = 0; e < DEPTH; e++) rd_mem[e] <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop_i) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PW'(1);
      end
      if (push_i) begin
        rd_mem[wr_ptr_q] <= push_rd_i;
        vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The head entry can be masked out when it retires this same cycle.
  always_comb begin
    hit_o = '0;
    for (int k = 0; k < NARGS; k++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (cmp_en_i[k] && vld_q[e] &&
            (rd_mem[e] == cmp_addr_i[k*REG_AW +: REG_AW]) &&
            !(excl_head_i && (PW'(e) == rd_ptr_q)))
          hit_o[k] = 1'b1;
      end
    end
  end

  assign head_rd_o = rd_mem[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/rv32imf_apu_dispatcher.sv
// Core-side APU master: request FSM, rd scoreboard, writeback and sticky fflags.
// Optional macro RV32IMF_APU_POP_BYPASS_EN lets a same-cycle pop free a slot/hazard.
module rv32imf_apu_dispatcher
  import rv32imf_apu_core_pkg::*;
#(
  parameter int  DEPTH        = 4,
  parameter int  APU_NARGS    = APU_NARGS_CPU,
  parameter int  APU_WOP      = APU_WOP_CPU,
  parameter int  APU_NDSFLAGS = APU_NDSFLAGS_CPU,
  parameter int  APU_NUSFLAGS = APU_NUSFLAGS_CPU,
  parameter int  REG_AW       = 6,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        issue_valid_i,
  output logic                        issue_ready_o,
  input  logic [APU_NARGS*32-1:0]     issue_operands_i,
  input  logic [APU_WOP-1:0]          issue_op_i,
  input  logic [APU_NDSFLAGS-1:0]     issue_flags_i,
  input  logic [REG_AW-1:0]           issue_rd_i,
  input  logic [APU_NARGS*REG_AW-1:0] issue_rs_i,
  input  logic [APU_NARGS-1:0]        issue_rs_used_i,
  output logic                        apu_req_o,
  input  logic                        apu_gnt_i,
  output logic [APU_NARGS*32-1:0]     apu_operands_o,
  output logic [APU_WOP-1:0]          apu_op_o,
  output logic [APU_NDSFLAGS-1:0]     apu_flags_o,
  input  logic                        apu_rvalid_i,
  input  logic [31:0]                 apu_rdata_i,
  input  logic [APU_NUSFLAGS-1:0]     apu_rflags_i,
  output logic                        wb_valid_o,
  output logic [REG_AW-1:0]           wb_addr_o,
  output logic [31:0]                 wb_data_o,
  output logic [APU_NUSFLAGS-1:0]     fflags_o,
  input  logic                        fflags_clr_i,
  output logic                        busy_o,
  output logic                        err_o,
  output req_state_e                  req_state_o
);

  // Issue handshake: an op transfers on a cycle where issue_valid_i and
  // issue_ready_o are both high; ready never depends on valid.
  req_state_e            state_q, state_d;
  apu_req_t              req_q;
  logic [CW-1:0]         count;
  logic [REG_AW-1:0]     head_rd;
  logic [APU_NARGS-1:0]  rs_hit;
  logic                  pop, accept, room, hazard, excl_head;

  assign pop = apu_rvalid_i && (count != '0);

`ifdef RV32IMF_APU_POP_BYPASS_EN
  assign excl_head = pop;
  assign room      = (count < CW'(DEPTH)) || pop;
`else
  assign excl_head = 1'b0;
  assign room      = count < CW'(DEPTH);
`endif

  assign hazard        = |rs_hit;
  assign issue_ready_o = ((state_q == REQ_IDLE) || apu_gnt_i) && room && !hazard;
  assign accept        = issue_valid_i && issue_ready_o;

  rv32imf_apu_rd_fifo #(
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW),
    .NARGS  (APU_NARGS)
  ) u_rd_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (accept),
    .push_rd_i   (issue_rd_i),
    .pop_i       (pop),
    .excl_head_i (excl_head),
    .cmp_addr_i  (issue_rs_i),
    .cmp_en_i    (issue_rs_used_i),
    .hit_o       (rs_hit),
    .head_rd_o   (head_rd),
    .count_o     (count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ_IDLE: if (accept) state_d = REQ_PEND;
      REQ_PEND: if (apu_gnt_i) state_d = accept ? REQ_PEND : REQ_IDLE;
    endcase
  end

  // Clear plus a pop restarts the sticky flags from this response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= REQ_IDLE;
      req_q      <= '0;
      wb_valid_o <= 1'b0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
      fflags_o   <= '0;
      err_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.operands <= issue_operands_i;
        req_q.op       <= issue_op_i;
        req_q.flags    <= issue_flags_i;
      end
      wb_valid_o <= pop;
      if (pop) begin
        wb_addr_o <= head_rd;
        wb_data_o <= apu_rdata_i;
        fflags_o  <= fflags_clr_i ? apu_rflags_i : (fflags_o | apu_rflags_i);
      end else if (fflags_clr_i) begin
        fflags_o <= '0;
      end
      if (apu_rvalid_i && (count == '0)) err_o <= 1'b1;
    end
  end

  assign apu_req_o      = (state_q == REQ_PEND);
  assign apu_operands_o = req_q.operands;
  assign apu_op_o       = req_q.op;
  assign apu_flags_o    = req_q.flags;
  assign busy_o         = (count != '0) || apu_req_o;
  assign req_state_o    = state_q;

endmodule
